// File: rtl/booth_mac_pkg.sv
// Shared types and constants for the Booth MAC accumulator datapath.
package booth_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_PROD_W = 64;
  localparam int DEF_ACC_W  = 72;
  localparam int DEF_CNT_W  = 8;

  // Wide enough for any practical accumulator; callers truncate to ACC_W bits.
  localparam int SAT_W = 256;

  function automatic logic [SAT_W-1:0] sat_max(input int accW);
    return (SAT_W'(1) << (accW - 1)) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int accW);
    return SAT_W'(1) << (accW - 1);
  endfunction

endpackage

// File: rtl/booth_mac_accumulator_if.sv
// Product-in / result-out handshake bundle for the Booth MAC accumulator.
interface booth_mac_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 8
);
  logic                     start;
  logic [CNT_W-1:0]         len;
  logic                     prod_valid;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_ready;
  logic                     acc_valid;
  logic                     acc_ready;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     busy;
  logic                     overflow;

  modport master (
    output start, len, prod_valid, prod, acc_ready,
    input  prod_ready, acc_valid, acc_out, busy, overflow
  );

  modport slave (
    input  start, len, prod_valid, prod, acc_ready,
    output prod_ready, acc_valid, acc_out, busy, overflow
  );
endinterface

// File: rtl/acc_sat_adder.sv
// Signed accumulator adder with overflow detect; clamps on overflow when
// BOOTH_MAC_SATURATE_EN is defined, otherwise wraps.
module acc_sat_adder
  import booth_mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [ACC_W-1:0] i_addend,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);
  logic signed [ACC_W-1:0] w_raw;

  assign w_raw = i_acc + i_addend;
  assign o_ovf = (i_acc[ACC_W-1] == i_addend[ACC_W-1]) &&
                 (w_raw[ACC_W-1] != i_acc[ACC_W-1]);

`ifdef BOOTH_MAC_SATURATE_EN
  // Overflow direction follows the (shared) operand sign.
  always_comb begin
    o_sum = w_raw;
    if (o_ovf) begin
      o_sum = i_acc[ACC_W-1] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
    end
  end
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/booth_mac_accumulator.sv
// Sums a programmed run of signed Booth products, then offers the total on a
// valid/ready port. Define BOOTH_MAC_SATURATE_EN for clamping instead of wrap.
module booth_mac_accumulator
  import booth_mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  booth_mac_accumulator_if.slave     bus
);
  state_e                  r_state;
  state_e                  w_nextState;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prodExt;
  logic signed [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0]        r_remaining;
  logic                    r_overflow;
  logic                    w_ovf;
  logic                    w_startAccept;
  logic                    w_prodAccept;

  assign w_startAccept = (r_state == IDLE) && bus.start;
  assign w_prodAccept  = (r_state == ACCUM) && bus.prod_valid;
  assign w_prodExt     = ACC_W'($signed(bus.prod));

  acc_sat_adder #(.ACC_W(ACC_W)) u_adder (
    .i_acc    (r_acc),
    .i_addend (w_prodExt),
    .o_sum    (w_sum),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Result port only exposes the sum in DONE so it reads 0 elsewhere.
  always_comb begin
    w_nextState    = r_state;
    bus.prod_ready = 1'b0;
    bus.acc_valid  = 1'b0;
    bus.acc_out    = '0;
    bus.busy       = 1'b1;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_nextState = (bus.len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        bus.prod_ready = 1'b1;
        if (bus.prod_valid && (r_remaining == CNT_W'(1))) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        bus.acc_valid = 1'b1;
        bus.acc_out   = r_acc;
        if (bus.acc_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_remaining <= '0;
      r_overflow  <= 1'b0;
    end else if (w_startAccept) begin
      r_acc       <= '0;
      r_remaining <= bus.len;
      r_overflow  <= 1'b0;
    end else if (w_prodAccept) begin
      r_acc       <= w_sum;
      r_remaining <= r_remaining - CNT_W'(1);
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.overflow = r_overflow;

endmodule
